// File: rtl/cpu_step_ctrl.sv
// Execution controller for the DE-board single-cycle CPU: debounces KEY[1] and turns it into
// single-step, burst, divided-run and full-speed-run clock enables with a PC breakpoint.
module cpu_step_ctrl #(
   parameter int PC_W       = 32,
   parameter int BURST_W    = 8,
   parameter int DEB_CYCLES = 500_000,
   parameter int RUN_DIV    = 25_000_000,
   parameter int CNT_W      = 16
) (
   input  logic               CLOCK_50,
   input  logic               rst_n,
   input  logic               step_key_n,
   input  logic [1:0]         mode,
   input  logic [BURST_W-1:0] burst_len,
   input  logic               bp_en,
   input  logic [PC_W-1:0]    bp_addr,
   input  logic [PC_W-1:0]    pc,
   output logic               cpu_ce,
   output logic               halted,
   output logic [CNT_W-1:0]   step_count,
   output logic [1:0]         state
);

   localparam int DEB_W = $clog2(DEB_CYCLES + 1);
   localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      STEP  = 2'd1,
      BURST = 2'd2,
      RUN   = 2'd3
   } state_t;

   state_t cur_state, nxt_state;

   logic               key_meta, key_sync, key_filt, key_filt_d;
   logic [DEB_W-1:0]   deb_cnt;
   logic               press;
   logic [BURST_W-1:0] remaining;
   logic [DIV_W-1:0]   div_cnt;
   logic               run_full;
   logic               first_pulse;
   logic               bp_stop;
   logic               run_due;

   // Key idles high, so the synchroniser and filter also come out of reset high.
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         key_meta   <= 1'b1;
         key_sync   <= 1'b1;
         key_filt   <= 1'b1;
         key_filt_d <= 1'b1;
         deb_cnt    <= '0;
      end else begin
         key_meta   <= step_key_n;
         key_sync   <= key_meta;
         key_filt_d <= key_filt;
         if (key_sync == key_filt) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
            key_filt <= key_sync;
            deb_cnt  <= '0;
         end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
         end
      end
   end

   assign press = key_filt_d & ~key_filt;

   // The very first pulse after a press ignores the breakpoint so a resume can step off it.
   assign bp_stop = bp_en && (pc == bp_addr) && !first_pulse;
   assign run_due = run_full || (div_cnt == '0);

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         cur_state <= IDLE;
      end else begin
         cur_state <= nxt_state;
      end
   end

   always_comb begin
      nxt_state = cur_state;
      case (cur_state)
         IDLE: begin
            if (press) begin
               if (mode == 2'b00) begin
                  nxt_state = STEP;
               end else if (mode == 2'b01) begin
                  nxt_state = BURST;
               end else begin
                  nxt_state = RUN;
               end
            end
         end
         STEP:    nxt_state = IDLE;
         BURST: begin
            if (press || bp_stop || (remaining == BURST_W'(1))) begin
               nxt_state = IDLE;
            end
         end
         RUN: begin
            if (press || bp_stop) begin
               nxt_state = IDLE;
            end
         end
         default: nxt_state = IDLE;
      endcase
   end

   // An abort press takes priority over both the pulse and the breakpoint.
   always_comb begin
      cpu_ce = 1'b0;
      case (cur_state)
         STEP:    cpu_ce = 1'b1;
         BURST:   cpu_ce = !press && !bp_stop;
         RUN:     cpu_ce = !press && !bp_stop && run_due;
         default: cpu_ce = 1'b0;
      endcase
   end

   assign state = cur_state;

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         remaining   <= '0;
         div_cnt     <= '0;
         run_full    <= 1'b0;
         first_pulse <= 1'b0;
         halted      <= 1'b0;
         step_count  <= '0;
      end else begin
         step_count <= step_count + CNT_W'(cpu_ce);
         if ((cur_state == IDLE) && press) begin
            remaining   <= (burst_len == '0) ? BURST_W'(1) : burst_len;
            run_full    <= mode[0];
            div_cnt     <= '0;
            first_pulse <= 1'b1;
            halted      <= 1'b0;
         end else begin
            first_pulse <= 1'b0;
            if ((cur_state == BURST) && cpu_ce) begin
               remaining <= remaining - BURST_W'(1);
            end
            if (cur_state == RUN) begin
               div_cnt <= (div_cnt == DIV_W'(RUN_DIV - 1)) ? '0 : div_cnt + DIV_W'(1);
            end
            if (((cur_state == BURST) || (cur_state == RUN)) && !press && bp_stop) begin
               halted <= 1'b1;
            end
         end
      end
   end

endmodule
